wb_commit_ctrl: RTL and testbench

Write-back commit controller at the far end of the MEM/WB pipeline register. It consumes the registered WB-stage control bits (`RegWrite_wb`, `MemtoReg_wb`, `Jump_wb`, `JumpReg_wb`, `branchSel_wb`) with their data, and issues the register-file write. It resolves control-flow redirects toward fetch through a valid/ready handshake, then squashes wrong-path instructions for a fixed number of cycles. It also keeps a retired-instruction counter.

---
 rtl/wb_commit_ctrl_if.sv | 27 ++
 rtl/wb_commit_ctrl.sv | 66 ++++++
 tb/tb_wb_commit_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/wb_commit_ctrl_if.sv
// wb_commit_ctrl_if: WB-stage commit bus between the MEM/WB register (master) and the commit controller (slave).
interface wb_commit_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              valid_wb, RegWrite_wb, MemtoReg_wb, Jump_wb, JumpReg_wb, branchSel_wb;
    logic [REG_AW-1:0] wreg_wb;
    logic [DATA_W-1:0] alu_result_wb, mem_rdata_wb, jump_target_wb, branch_target_wb, rs_value_wb;
    logic              redirect_ready;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              stall_out, flush_out;
    logic [31:0]       retired_count;
    modport master (
        output valid_wb, RegWrite_wb, MemtoReg_wb, Jump_wb, JumpReg_wb, branchSel_wb, wreg_wb,
               alu_result_wb, mem_rdata_wb, jump_target_wb, branch_target_wb, rs_value_wb, redirect_ready,
        input  rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_pc, stall_out, flush_out, retired_count
    );
    modport slave (
        input  valid_wb, RegWrite_wb, MemtoReg_wb, Jump_wb, JumpReg_wb, branchSel_wb, wreg_wb,
               alu_result_wb, mem_rdata_wb, jump_target_wb, branch_target_wb, rs_value_wb, redirect_ready,
        output rf_we, rf_waddr, rf_wdata, redirect_valid, redirect_pc, stall_out, flush_out, retired_count
    );
endinterface

// File: rtl/wb_commit_ctrl.sv
// wb_commit_ctrl: commits WB-stage writes, hands redirects to fetch, then squashes the wrong path.
module wb_commit_ctrl #(
    parameter int DATA_W        = 32,
    parameter int REG_AW        = 5,
    parameter int SQUASH_CYCLES = 3
) (
    input logic             clk,
    input logic             reset,
    wb_commit_ctrl_if.slave bus
);
    localparam int CW = SQUASH_CYCLES > 1 ? $clog2(SQUASH_CYCLES + 1) : 1;
    typedef enum logic [1:0] {IDLE, REDIRECT, SQUASH} state_t;
    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [31:0]       retired;
    logic              commit, redir;
    logic [DATA_W-1:0] target;
    assign commit = bus.valid_wb && state == IDLE;
    assign redir  = commit && (bus.JumpReg_wb || bus.Jump_wb || bus.branchSel_wb);
    assign target = bus.JumpReg_wb ? bus.rs_value_wb : bus.Jump_wb ? bus.jump_target_wb : bus.branch_target_wb;
    assign bus.retired_count = retired;
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE:     if (redir) state_n = REDIRECT;
            REDIRECT: if (bus.redirect_ready) begin
                state_n = SQUASH_CYCLES == 0 ? IDLE : SQUASH;
                cnt_n   = CW'(SQUASH_CYCLES);
            end
            SQUASH: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) state_n = IDLE;
            end
            default:  state_n = IDLE;
        endcase
    end
    // status outputs are flopped copies of the next state so they never glitch
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            cnt                <= '0;
            retired            <= '0;
            bus.rf_we          <= 1'b0;
            bus.rf_waddr       <= '0;
            bus.rf_wdata       <= '0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.stall_out      <= 1'b0;
            bus.flush_out      <= 1'b0;
        end else begin
            state              <= state_n;
            cnt                <= cnt_n;
            retired            <= retired + 32'(commit);
            bus.rf_we          <= commit && bus.RegWrite_wb && bus.wreg_wb != REG_AW'(0);
            if (commit) begin
                bus.rf_waddr   <= bus.wreg_wb;
                bus.rf_wdata   <= bus.MemtoReg_wb ? bus.mem_rdata_wb : bus.alu_result_wb;
            end
            if (redir) bus.redirect_pc <= target;
            bus.redirect_valid <= state_n == REDIRECT;
            bus.stall_out      <= state_n == REDIRECT;
            bus.flush_out      <= state_n == SQUASH;
        end
    end
endmodule

// File: tb/tb_wb_commit_ctrl.sv
// tb_wb_commit_ctrl: scoreboard bench; dut0 uses 3 squash cycles, dut1 uses none.
module tb_wb_commit_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    wb_commit_ctrl_if #(.DATA_W(32), .REG_AW(5)) b0 ();
    wb_commit_ctrl_if #(.DATA_W(32), .REG_AW(5)) b1 ();
    wb_commit_ctrl #(.DATA_W(32), .REG_AW(5), .SQUASH_CYCLES(3)) dut0 (.clk(clk), .reset(reset), .bus(b0.slave));
    wb_commit_ctrl #(.DATA_W(32), .REG_AW(5), .SQUASH_CYCLES(0)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
    // {rf_we, rf_waddr, rf_wdata, retired_count, redirect_valid, stall_out, flush_out, redirect_pc}
    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] rc;
        logic [2:0]  vsf;
        logic [31:0] pc;
    } snap_t;
    snap_t q0[$], q1[$];
    int checks = 0, errors = 0;
    function automatic snap_t obs0();
        return {b0.rf_we, b0.rf_waddr, b0.rf_wdata, b0.retired_count, b0.redirect_valid, b0.stall_out, b0.flush_out, b0.redirect_pc};
    endfunction
    function automatic snap_t obs1();
        return {b1.rf_we, b1.rf_waddr, b1.rf_wdata, b1.retired_count, b1.redirect_valid, b1.stall_out, b1.flush_out, b1.redirect_pc};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic drv(input logic v, rw, m2r, j, jr, br, input logic [4:0] w, input logic [31:0] alu, mem, input logic rdy);
        b0.valid_wb = v; b0.RegWrite_wb = rw; b0.MemtoReg_wb = m2r;
        b0.Jump_wb = j; b0.JumpReg_wb = jr; b0.branchSel_wb = br;
        b0.wreg_wb = w; b0.alu_result_wb = alu; b0.mem_rdata_wb = mem; b0.redirect_ready = rdy;
    endtask
    task automatic drv1(input logic v, rw, br, input logic [4:0] w, input logic [31:0] alu);
        b1.valid_wb = v; b1.RegWrite_wb = rw; b1.MemtoReg_wb = 1'b0;
        b1.Jump_wb = 1'b0; b1.JumpReg_wb = 1'b0; b1.branchSel_wb = br;
        b1.wreg_wb = w; b1.alu_result_wb = alu; b1.mem_rdata_wb = 32'h0; b1.redirect_ready = 1'b1;
    endtask
    task automatic test_reset();
        snap_t g, e;
        b0.jump_target_wb = 32'h0; b0.branch_target_wb = 32'h0; b0.rs_value_wb = 32'h0;
        b1.jump_target_wb = 32'h0; b1.branch_target_wb = 32'h20; b1.rs_value_wb = 32'h0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 32'h99, 32'h0, 1'b1);
            drv1(1'b1, 1'b1, 1'b1, 5'd3, 32'h99);
            q0.push_back('0);
            q1.push_back('0);
            tick();
            g = obs0(); e = q0.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL reset0 got %h exp %h", g, e); end
            g = obs1(); e = q1.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL reset1 got %h exp %h", g, e); end
        end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
        drv1(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        reset = 1'b0;
    endtask
    task automatic test_alu();
        snap_t g, e;
        for (int i = 0; i < 2; i++) begin
            drv(i == 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd8, 32'h1234, 32'h0, 1'b1);
            q0.push_back({i == 0, 5'd8, 32'h1234, 32'd1, 3'b000, 32'h0});
            tick();
            g = obs0(); e = q0.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL alu[%0d] got %h exp %h", i, g, e); end
        end
    endtask
    task automatic test_load();
        snap_t g, e;
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, i == 0 ? 5'd9 : 5'd0, 32'h55, i == 0 ? 32'hDEADBEEF : 32'h5555, 1'b1);
            q0.push_back(i == 0 ? {1'b1, 5'd9, 32'hDEADBEEF, 32'd2, 3'b000, 32'h0}
                                : {1'b0, 5'd0, 32'h5555, 32'd3, 3'b000, 32'h0});
            tick();
            g = obs0(); e = q0.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL load[%0d] got %h exp %h", i, g, e); end
        end
    endtask
    task automatic test_jal_stall();
        snap_t g, e;
        b0.jump_target_wb = 32'h400;
        for (int i = 0; i < 8; i++) begin
            drv(1'b1, 1'b1, 1'b0, i == 0, 1'b0, 1'b0, i == 0 ? 5'd31 : 5'd5, i == 0 ? 32'h1004 : 32'h77, 32'h0, i >= 3);
            case (i)
                0:       q0.push_back({1'b1, 5'd31, 32'h1004, 32'd4, 3'b110, 32'h400});
                1, 2:    q0.push_back({1'b0, 5'd31, 32'h1004, 32'd4, 3'b110, 32'h400});
                3, 4, 5: q0.push_back({1'b0, 5'd31, 32'h1004, 32'd4, 3'b001, 32'h400});
                6:       q0.push_back({1'b0, 5'd31, 32'h1004, 32'd4, 3'b000, 32'h400});
                default: q0.push_back({1'b1, 5'd5, 32'h77, 32'd5, 3'b000, 32'h400});
            endcase
            tick();
            g = obs0(); e = q0.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL jal[%0d] got %h exp %h", i, g, e); end
        end
    endtask
    task automatic test_priority();
        snap_t g, e;
        b0.rs_value_wb = 32'h80; b0.jump_target_wb = 32'h400; b0.branch_target_wb = 32'h20;
        for (int i = 0; i < 5; i++) begin
            drv(i == 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3, 32'h33, 32'h0, 1'b1);
            q0.push_back({1'b0, 5'd3, 32'h33, 32'd6, i == 0 ? 3'b110 : i == 4 ? 3'b000 : 3'b001, 32'h80});
            tick();
            g = obs0(); e = q0.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL prio[%0d] got %h exp %h", i, g, e); end
        end
        drv(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b1);
    endtask
    task automatic test_no_squash();
        snap_t g, e;
        for (int i = 0; i < 3; i++) begin
            drv1(1'b1, 1'b1, i == 0, i == 0 ? 5'd4 : 5'd6, i == 0 ? 32'h44 : 32'h66);
            case (i)
                0:       q1.push_back({1'b1, 5'd4, 32'h44, 32'd1, 3'b110, 32'h20});
                1:       q1.push_back({1'b0, 5'd4, 32'h44, 32'd1, 3'b000, 32'h20});
                default: q1.push_back({1'b1, 5'd6, 32'h66, 32'd2, 3'b000, 32'h20});
            endcase
            tick();
            g = obs1(); e = q1.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL nosquash[%0d] got %h exp %h", i, g, e); end
        end
        drv1(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask
    task automatic test_reset_mid_squash();
        snap_t g, e;
        b0.branch_target_wb = 32'h20;
        for (int i = 0; i < 4; i++) begin
            reset = i == 2;
            drv(i == 0 || i == 3, 1'b1, 1'b0, 1'b0, 1'b0, i == 0, i == 0 ? 5'd7 : 5'd2, i == 0 ? 32'h70 : 32'h22, 32'h0, 1'b1);
            case (i)
                0:       q0.push_back({1'b1, 5'd7, 32'h70, 32'd7, 3'b110, 32'h20});
                1:       q0.push_back({1'b0, 5'd7, 32'h70, 32'd7, 3'b001, 32'h20});
                2:       q0.push_back('0);
                default: q0.push_back({1'b1, 5'd2, 32'h22, 32'd1, 3'b000, 32'h0});
            endcase
            tick();
            g = obs0(); e = q0.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL midsquash[%0d] got %h exp %h", i, g, e); end
        end
        reset = 1'b0;
    endtask
    task automatic test_wrap();
        snap_t g, e;
        force dut0.retired = 32'hFFFF_FFFF;
        #1;
        release dut0.retired;
        for (int i = 0; i < 2; i++) begin
            drv(1'b1, i == 0, 1'b0, 1'b0, 1'b0, 1'b0, i == 0 ? 5'd10 : 5'd11, i == 0 ? 32'hAA : 32'hBB, 32'h0, 1'b1);
            q0.push_back(i == 0 ? {1'b1, 5'd10, 32'hAA, 32'd0, 3'b000, 32'h0}
                                : {1'b0, 5'd11, 32'hBB, 32'd1, 3'b000, 32'h0});
            tick();
            g = obs0(); e = q0.pop_front(); checks++;
            if (g !== e) begin errors++; $display("FAIL wrap[%0d] got %h exp %h", i, g, e); end
        end
    endtask
    initial begin
        test_reset();
        test_alu();
        test_load();
        test_jal_stall();
        test_priority();
        test_no_squash();
        test_reset_mid_squash();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
